// File: rtl/reservation_station_pkg.sv
// Shared types for the ALU-class reservation station: widths, opcode enum,
// entry layout and the CDB operand-capture helper.
package reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = 4;
    localparam int ROB_IDX_W = 4;
    localparam int OPENUM_W  = 6;

    typedef logic [31:0]           data_t;
    typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
    typedef logic [RS_IDX_W-1:0]   rs_idx_t;
    typedef logic [OPENUM_W-1:0]   openum_t;

    typedef enum logic [OPENUM_W-1:0] {
        OPENUM_NOP, OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
        OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
        OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI,
        OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
        OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
        OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
    } openum_e;

    typedef struct packed {
        logic     ready;
        rob_idx_t tag;
        data_t    val;
    } cdb_t;

    typedef struct packed {
        data_t    val;
        rob_idx_t tag;
    } operand_t;

    typedef struct packed {
        logic     valid;
        openum_t  op;
        data_t    v1;
        rob_idx_t q1;
        data_t    v2;
        rob_idx_t q2;
        data_t    imm;
        data_t    pc;
        rob_idx_t rob_index;
    } rs_entry_t;

    // Capture a CDB value for a waiting operand; tag 0 already holds its value.
    function automatic operand_t resolve(input data_t val, input rob_idx_t tag,
                                         input cdb_t alu, input cdb_t lsb);
        resolve = '{val: val, tag: tag};
        if (tag != '0) begin
            if (alu.ready && alu.tag == tag)
                resolve = '{val: alu.val, tag: '0};
            else if (lsb.ready && lsb.tag == tag)
                resolve = '{val: lsb.val, tag: '0};
        end
    endfunction

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit finder: returns the index of the lowest asserted request
// and whether any request was asserted.
module rs_priority_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU-class reservation station: buffers issued ops, wakes operands from the
// ALU/LSB CDBs, and dispatches the lowest-indexed ready entry per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rollback,
    input  logic                 issue_ready,
    input  logic                 issue_rs_ready,
    input  logic [OPENUM_W-1:0]  issue_op,
    input  logic [31:0]          issue_rs1_val,
    input  logic [ROB_IDX_W-1:0] issue_rs1_depend,
    input  logic [31:0]          issue_rs2_val,
    input  logic [ROB_IDX_W-1:0] issue_rs2_depend,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_PC,
    input  logic [ROB_IDX_W-1:0] issue_rob_index,
    input  logic                 alu_result_ready,
    input  logic [ROB_IDX_W-1:0] alu_result_rob_index,
    input  logic [31:0]          alu_result_val,
    input  logic                 lsb_result_ready,
    input  logic [ROB_IDX_W-1:0] lsb_result_rob_index,
    input  logic [31:0]          lsb_result_val,
    output logic                 rs_full,
    output logic                 rs_to_alu_ready,
    output logic [OPENUM_W-1:0]  rs_to_alu_op,
    output logic [31:0]          rs_to_alu_rs1_val,
    output logic [31:0]          rs_to_alu_rs2_val,
    output logic [31:0]          rs_to_alu_imm,
    output logic [31:0]          rs_to_alu_PC,
    output logic [ROB_IDX_W-1:0] rs_to_alu_rob_index
);

    rs_entry_t        entries [RS_SIZE];
    rs_entry_t        woken   [RS_SIZE];
    operand_t         op1_w   [RS_SIZE];
    operand_t         op2_w   [RS_SIZE];
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    rs_idx_t          free_idx;
    rs_idx_t          sel_idx;
    logic             free_found;
    logic             sel_found;
    cdb_t             alu_cdb;
    cdb_t             lsb_cdb;
    operand_t         iss1;
    operand_t         iss2;
    rs_entry_t        new_entry;
    logic             issue_fire;

    assign alu_cdb = '{ready: alu_result_ready, tag: alu_result_rob_index, val: alu_result_val};
    assign lsb_cdb = '{ready: lsb_result_ready, tag: lsb_result_rob_index, val: lsb_result_val};

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !entries[i].valid;
            ready_vec[i] = entries[i].valid && entries[i].q1 == '0 && entries[i].q2 == '0;
        end
    end

    rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_enc (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Full only counts registered occupancy; a same-cycle dispatch frees nothing yet.
    assign rs_full    = !free_found;
    assign issue_fire = issue_ready && issue_rs_ready && free_found;

    // Both CDBs may complete different operands of the same entry this cycle.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            woken[i] = entries[i];
            op1_w[i] = resolve(entries[i].v1, entries[i].q1, alu_cdb, lsb_cdb);
            op2_w[i] = resolve(entries[i].v2, entries[i].q2, alu_cdb, lsb_cdb);
            if (entries[i].valid) begin
                woken[i].v1 = op1_w[i].val;
                woken[i].q1 = op1_w[i].tag;
                woken[i].v2 = op2_w[i].val;
                woken[i].q2 = op2_w[i].tag;
            end
        end
    end

    assign iss1 = resolve(issue_rs1_val, issue_rs1_depend, alu_cdb, lsb_cdb);
    assign iss2 = resolve(issue_rs2_val, issue_rs2_depend, alu_cdb, lsb_cdb);

    always_comb begin
        new_entry = '{valid:     1'b1,
                      op:        issue_op,
                      v1:        iss1.val,
                      q1:        iss1.tag,
                      v2:        iss2.val,
                      q2:        iss2.tag,
                      imm:       issue_imm,
                      pc:        issue_PC,
                      rob_index: issue_rob_index};
    end

    // NOTE: all state here uses non-blocking assignment so every read sees
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: only the valid bits are reset; payload fields are never
            // read while invalid, so clearing the storage would be wasted logic.
            for (int i = 0; i < RS_SIZE; i++)
                entries[i].valid <= 1'b0;
            rs_to_alu_ready     <= 1'b0;
            rs_to_alu_op        <= '0;
            rs_to_alu_rs1_val   <= '0;
            rs_to_alu_rs2_val   <= '0;
            rs_to_alu_imm       <= '0;
            rs_to_alu_PC        <= '0;
            rs_to_alu_rob_index <= '0;
        end else if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++)
                entries[i].valid <= 1'b0;
            rs_to_alu_ready <= 1'b0;
        end else if (!rdy_in) begin
            rs_to_alu_ready <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++)
                entries[i] <= woken[i];

            if (sel_found) begin
                rs_to_alu_ready         <= 1'b1;
                rs_to_alu_op            <= entries[sel_idx].op;
                rs_to_alu_rs1_val       <= entries[sel_idx].v1;
                rs_to_alu_rs2_val       <= entries[sel_idx].v2;
                rs_to_alu_imm           <= entries[sel_idx].imm;
                rs_to_alu_PC            <= entries[sel_idx].pc;
                rs_to_alu_rob_index     <= entries[sel_idx].rob_index;
                entries[sel_idx].valid  <= 1'b0;
            end else begin
                rs_to_alu_ready <= 1'b0;
            end

            // The free slot is never the dispatching one: that entry is still valid.
            if (issue_fire)
                entries[free_idx] <= new_entry;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: scoreboard of expected
// dispatches, a forwarding vector table, and hand-written timing sequences.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rollback = 1'b0;
    logic        issue_ready = 1'b0;
    logic        issue_rs_ready = 1'b0;
    logic [5:0]  issue_op = '0;
    logic [31:0] issue_rs1_val = '0;
    logic [3:0]  issue_rs1_depend = '0;
    logic [31:0] issue_rs2_val = '0;
    logic [3:0]  issue_rs2_depend = '0;
    logic [31:0] issue_imm = '0;
    logic [31:0] issue_PC = '0;
    logic [3:0]  issue_rob_index = '0;
    logic        alu_result_ready = 1'b0;
    logic [3:0]  alu_result_rob_index = '0;
    logic [31:0] alu_result_val = '0;
    logic        lsb_result_ready = 1'b0;
    logic [3:0]  lsb_result_rob_index = '0;
    logic [31:0] lsb_result_val = '0;
    logic        rs_full;
    logic        rs_to_alu_ready;
    logic [5:0]  rs_to_alu_op;
    logic [31:0] rs_to_alu_rs1_val;
    logic [31:0] rs_to_alu_rs2_val;
    logic [31:0] rs_to_alu_imm;
    logic [31:0] rs_to_alu_PC;
    logic [3:0]  rs_to_alu_rob_index;

    reservation_station dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .rollback             (rollback),
        .issue_ready          (issue_ready),
        .issue_rs_ready       (issue_rs_ready),
        .issue_op             (issue_op),
        .issue_rs1_val        (issue_rs1_val),
        .issue_rs1_depend     (issue_rs1_depend),
        .issue_rs2_val        (issue_rs2_val),
        .issue_rs2_depend     (issue_rs2_depend),
        .issue_imm            (issue_imm),
        .issue_PC             (issue_PC),
        .issue_rob_index      (issue_rob_index),
        .alu_result_ready     (alu_result_ready),
        .alu_result_rob_index (alu_result_rob_index),
        .alu_result_val       (alu_result_val),
        .lsb_result_ready     (lsb_result_ready),
        .lsb_result_rob_index (lsb_result_rob_index),
        .lsb_result_val       (lsb_result_val),
        .rs_full              (rs_full),
        .rs_to_alu_ready      (rs_to_alu_ready),
        .rs_to_alu_op         (rs_to_alu_op),
        .rs_to_alu_rs1_val    (rs_to_alu_rs1_val),
        .rs_to_alu_rs2_val    (rs_to_alu_rs2_val),
        .rs_to_alu_imm        (rs_to_alu_imm),
        .rs_to_alu_PC         (rs_to_alu_PC),
        .rs_to_alu_rob_index  (rs_to_alu_rob_index)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } exp_t;

    typedef struct {
        logic        target;
        logic [5:0]  op;
        logic [31:0] v1;
        logic [3:0]  d1;
        logic [31:0] v2;
        logic [3:0]  d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic        a_rdy;
        logic [3:0]  a_tag;
        logic [31:0] a_val;
        logic        l_rdy;
        logic [3:0]  l_tag;
        logic [31:0] l_val;
        logic        exp_disp;
        logic [31:0] exp_v1;
        logic [31:0] exp_v2;
    } vec_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_disp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Advance one edge, then sample and score any dispatch.
    task automatic step();
        exp_t e;
        @(posedge clk_in);
        #1;
        n_disp = 0;
        if (rs_to_alu_ready) begin
            n_disp = 1;
            check("dispatch_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("disp_op",  32'(rs_to_alu_op), 32'(e.op));
                check("disp_rs1", rs_to_alu_rs1_val, e.v1);
                check("disp_rs2", rs_to_alu_rs2_val, e.v2);
                check("disp_imm", rs_to_alu_imm, e.imm);
                check("disp_pc",  rs_to_alu_PC, e.pc);
                check("disp_rob", 32'(rs_to_alu_rob_index), 32'(e.rob));
            end
        end
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] d1,
                             input logic [31:0] v2, input logic [3:0] d2, input logic [31:0] imm,
                             input logic [31:0] pc, input logic [3:0] rob);
        check("issue_while_not_full", 32'(rs_full), 32'd0);
        issue_ready = 1'b1; issue_rs_ready = 1'b1;
        issue_op = op; issue_rs1_val = v1; issue_rs1_depend = d1;
        issue_rs2_val = v2; issue_rs2_depend = d2;
        issue_imm = imm; issue_PC = pc; issue_rob_index = rob;
    endtask

    task automatic clear_inputs();
        issue_ready = 1'b0; issue_rs_ready = 1'b0;
        alu_result_ready = 1'b0; lsb_result_ready = 1'b0;
        alu_result_rob_index = '0; lsb_result_rob_index = '0;
        rollback = 1'b0;
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        exp_t e;
        e = '{op: op, v1: v1, v2: v2, imm: imm, pc: pc, rob: rob};
        exp_q.push_back(e);
    endtask

    vec_t vecs[$];

    initial begin
        // Same-cycle forwarding and tag-0 vectors, each checked for two-edge latency.
        vecs.push_back('{1'b1, OPENUM_ADD, 32'h0, 4'd4, 32'h1, 4'd0, 32'h0, 32'h700, 4'd2,
                         1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'hAB, 1'b1, 32'hAB, 32'h1});
        vecs.push_back('{1'b1, OPENUM_SUB, 32'h0, 4'd2, 32'h0, 4'd3, 32'h0, 32'h704, 4'd4,
                         1'b1, 4'd2, 32'h1111, 1'b1, 4'd3, 32'h2222, 1'b1, 32'h1111, 32'h2222});
        vecs.push_back('{1'b1, OPENUM_ADDI, 32'h77, 4'd0, 32'h0, 4'd0, 32'h3, 32'h708, 4'd5,
                         1'b1, 4'd0, 32'hDEAD, 1'b1, 4'd0, 32'hBEEF, 1'b1, 32'h77, 32'h0});
        vecs.push_back('{1'b1, OPENUM_XOR, 32'h12, 4'd0, 32'h0, 4'd6, 32'h0, 32'h70C, 4'd7,
                         1'b1, 4'd6, 32'h3456, 1'b0, 4'd0, 32'h0, 1'b1, 32'h12, 32'h3456});
        vecs.push_back('{1'b0, OPENUM_ADD, 32'h1, 4'd0, 32'h2, 4'd0, 32'h0, 32'h710, 4'd8,
                         1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, OPENUM_OR, 32'h0, 4'd8, 32'h5, 4'd0, 32'h0, 32'h714, 4'd9,
                         1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, OPENUM_LUI, 32'h0, 4'd0, 32'h0, 4'd0, 32'hABCDE000, 32'h718, 4'd10,
                         1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0, 32'h0});
        vecs.push_back('{1'b1, OPENUM_AND, 32'h0, 4'd5, 32'h0, 4'd5, 32'h0, 32'h71C, 4'd11,
                         1'b1, 4'd5, 32'h5, 1'b0, 4'd0, 32'h0, 1'b1, 32'h5, 32'h5});

        // Reset
        rst_in = 1'b1;
        step(); step();
        rst_in = 1'b0;
        check("reset_full",  32'(rs_full), 32'd0);
        check("reset_ready", 32'(rs_to_alu_ready), 32'd0);
        check("reset_op",    32'(rs_to_alu_op), 32'd0);
        check("reset_rs1",   rs_to_alu_rs1_val, 32'd0);
        check("reset_rob",   32'(rs_to_alu_rob_index), 32'd0);

        // Ready ADDI: dispatch visible after the second edge, data holds afterwards.
        set_issue(OPENUM_ADDI, 32'd5, 4'd0, 32'd0, 4'd0, 32'd7, 32'h100, 4'd3);
        push(OPENUM_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3);
        step(); clear_inputs();
        check("t1_no_early", 32'(n_disp), 32'd0);
        check("t1_full0", 32'(rs_full), 32'd0);
        step();
        check("t1_disp", 32'(n_disp), 32'd1);
        check("t1_full1", 32'(rs_full), 32'd0);
        step();
        check("t1_one_shot", 32'(n_disp), 32'd0);
        check("t1_hold_rs1", rs_to_alu_rs1_val, 32'd5);
        check("t1_hold_rob", 32'(rs_to_alu_rob_index), 32'd3);

        // Dependent ADD woken by ALU CDB two cycles after issue.
        set_issue(OPENUM_ADD, 32'd0, 4'd2, 32'd9, 4'd0, 32'd0, 32'h200, 4'd1);
        push(OPENUM_ADD, 32'h10, 32'd9, 32'd0, 32'h200, 4'd1);
        step(); clear_inputs();
        check("t2_wait0", 32'(n_disp), 32'd0);
        step();
        check("t2_wait1", 32'(n_disp), 32'd0);
        alu_result_ready = 1'b1; alu_result_rob_index = 4'd2; alu_result_val = 32'h10;
        step(); clear_inputs();
        check("t2_no_early", 32'(n_disp), 32'd0);
        step();
        check("t2_disp", 32'(n_disp), 32'd1);
        step();

        // Fill all 16 entries behind tag 5, then release them with one broadcast.
        for (int i = 0; i < RS_SIZE; i++) begin
            set_issue(OPENUM_ADD, 32'd0, 4'd5, 32'(i), 4'd0, 32'd0, 32'h400 + 32'(4 * i), 4'((i % 15) + 1));
            push(OPENUM_ADD, 32'h55, 32'(i), 32'd0, 32'h400 + 32'(4 * i), 4'((i % 15) + 1));
            step();
            check("t4_fill_nodisp", 32'(n_disp), 32'd0);
        end
        clear_inputs();
        check("t4_full", 32'(rs_full), 32'd1);
        alu_result_ready = 1'b1; alu_result_rob_index = 4'd5; alu_result_val = 32'h55;
        step(); clear_inputs();
        check("t4_full_after_cdb", 32'(rs_full), 32'd1);
        check("t4_no_early", 32'(n_disp), 32'd0);
        for (int i = 0; i < RS_SIZE; i++) begin
            step();
            check("t4_burst", 32'(n_disp), 32'd1);
            if (i == 0) check("t4_full_drop", 32'(rs_full), 32'd0);
        end
        step();
        check("t4_drained", 32'(n_disp), 32'd0);

        // Vector table
        foreach (vecs[k]) begin
            set_issue(vecs[k].op, vecs[k].v1, vecs[k].d1, vecs[k].v2, vecs[k].d2,
                      vecs[k].imm, vecs[k].pc, vecs[k].rob);
            issue_rs_ready = vecs[k].target;
            alu_result_ready = vecs[k].a_rdy; alu_result_rob_index = vecs[k].a_tag;
            alu_result_val = vecs[k].a_val;
            lsb_result_ready = vecs[k].l_rdy; lsb_result_rob_index = vecs[k].l_tag;
            lsb_result_val = vecs[k].l_val;
            if (vecs[k].exp_disp)
                push(vecs[k].op, vecs[k].exp_v1, vecs[k].exp_v2, vecs[k].imm, vecs[k].pc, vecs[k].rob);
            step(); clear_inputs();
            check("vec_no_early", 32'(n_disp), 32'd0);
            step();
            check("vec_disp", 32'(n_disp), 32'(vecs[k].exp_disp));
            if (!vecs[k].exp_disp) begin
                step(); check("vec_still_none", 32'(n_disp), 32'd0);
                rollback = 1'b1;
                step(); clear_inputs();
            end
            step();
        end

        // Rollback with 6 waiting entries, a ready entry about to dispatch, and a same-cycle issue.
        for (int i = 0; i < 6; i++) begin
            set_issue(OPENUM_ADD, 32'd0, 4'd7, 32'd1, 4'd0, 32'd0, 32'h500 + 32'(4 * i), 4'(i + 1));
            step();
        end
        set_issue(OPENUM_ADDI, 32'd1, 4'd0, 32'd0, 4'd0, 32'd1, 32'h520, 4'd9);
        step();
        set_issue(OPENUM_ADDI, 32'd2, 4'd0, 32'd0, 4'd0, 32'd2, 32'h524, 4'd10);
        rollback = 1'b1;
        step(); clear_inputs();
        check("t5_full", 32'(rs_full), 32'd0);
        check("t5_no_disp", 32'(n_disp), 32'd0);
        alu_result_ready = 1'b1; alu_result_rob_index = 4'd7; alu_result_val = 32'h1;
        step(); clear_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_flushed", 32'(n_disp), 32'd0);
        end

        // Stall: rdy_in low for 3 edges holds a pending ready entry and ignores issue/CDB.
        set_issue(OPENUM_XOR, 32'h33, 4'd0, 32'h44, 4'd0, 32'h5, 32'h600, 4'd11);
        push(OPENUM_XOR, 32'h33, 32'h44, 32'h5, 32'h600, 4'd11);
        step(); clear_inputs();
        rdy_in = 1'b0;
        set_issue(OPENUM_ADD, 32'h1, 4'd0, 32'h1, 4'd0, 32'h0, 32'h604, 4'd12);
        alu_result_ready = 1'b1; alu_result_rob_index = 4'd11; alu_result_val = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step(); clear_inputs();
            check("t6_stalled", 32'(n_disp), 32'd0);
        end
        rdy_in = 1'b1;
        step();
        check("t6_resume", 32'(n_disp), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_extra", 32'(n_disp), 32'd0);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the decoder's issue bus for ALU-class ops: LUI, AUIPC, JAL, JALR, R-type, I-type and branch.
- Buffers each issued instruction with its operand values or ROB-tag dependencies.
- Snoops the ALU and LSB result buses (CDB) to wake waiting operands.
- Dispatches the lowest-indexed ready entry to the ALU through a registered one-cycle-valid interface. Sits between the decoder/ROB and the ALU.

Parameters:
RS_SIZE, 16, number of entries
RS_IDX_W, 4, log2(RS_SIZE)
ROB_IDX_W, 4, ROB tag width; tag 0 is reserved and means "no dependency / value valid"
OPENUM_W, 6, width of the decoded opcode enum

Ports:
clk_in  in  1  clock; all state updates on rising edge
rst_in  in  1  synchronous, active-high reset
rdy_in  in  1  global enable; low = hold all state
rollback  in  1  mispredict flush
issue_ready  in  1  decoder issue valid
issue_rs_ready  in  1  issue is targeted at this block
issue_op  in  OPENUM_W  decoded op
issue_rs1_val  in  32  rs1 value (valid when depend==0)
issue_rs1_depend  in  ROB_IDX_W  rs1 producer tag, 0=ready
issue_rs2_val  in  32  rs2 value
issue_rs2_depend  in  ROB_IDX_W  rs2 producer tag
issue_imm  in  32  immediate
issue_PC  in  32  instruction PC
issue_rob_index  in  ROB_IDX_W  destination ROB tag (nonzero)
alu_result_ready  in  1  ALU CDB valid
alu_result_rob_index  in  ROB_IDX_W  ALU CDB tag
alu_result_val  in  32  ALU CDB data
lsb_result_ready  in  1  LSB CDB valid
lsb_result_rob_index  in  ROB_IDX_W  LSB CDB tag
lsb_result_val  in  32  LSB CDB data
rs_full  out  1  no free entry
rs_to_alu_ready  out  1  dispatch valid, one cycle
rs_to_alu_op  out  OPENUM_W  op
rs_to_alu_rs1_val  out  32  operand 1
rs_to_alu_rs2_val  out  32  operand 2
rs_to_alu_imm  out  32  immediate
rs_to_alu_PC  out  32  PC
rs_to_alu_rob_index  out  ROB_IDX_W  destination tag

Behaviour:
- Reset (rst_in high at an edge): all entries invalid, all outputs 0 (rs_full=0, rs_to_alu_ready=0).
- Priority per edge: rst_in > rollback > !rdy_in > normal operation.
- Rollback: all entries invalidated, rs_to_alu_ready=0 next cycle, a same-cycle issue is dropped.
- rdy_in low: entries, operands and occupancy hold. rs_to_alu_ready goes to 0. CDB and issue inputs are ignored.
- Entry fields: valid, op, v1, q1, v2, q2, imm, PC, rob_index. An entry is ready when valid && q1==0 && q2==0.
- rs_full is combinational from registered state: high when all RS_SIZE entries are valid. There is no credit for a same-cycle dispatch. The decoder must not issue while rs_full is high. An issue while full is dropped, and the bench flags it as an error.
- Issue (issue_ready && issue_rs_ready): written into the lowest-index invalid entry.
  - Each incoming operand with depend!=0 matching a same-cycle valid CDB tag (ALU first, then LSB) is stored with that CDB value and tag 0.
- Wakeup: for every valid entry and each CDB, if q==tag and the CDB is valid, then v<=val and q<=0. Both CDBs may wake different operands of the same entry in one cycle.
- Select: among entries ready in registered state, pick the lowest index.
  - At the edge, copy its fields to the rs_to_alu_* registers, set rs_to_alu_ready=1 and clear that entry's valid. Otherwise rs_to_alu_ready<=0.
  - Exactly one dispatch per cycle maximum.
- Latency:
  - Issue with both operands ready, sampled at edge t: eligible in cycle t+1, rs_to_alu_ready high in cycle t+2.
  - CDB wakeup at edge t: same timing.
- Simultaneous issue and dispatch: legal. The freed slot is reusable from the next cycle, not the same one.
- Tag 0 on a CDB never wakes anything.
- rs_to_alu_* data holds its last value when ready=0.

Decomposition:
- Shared defines header, already in use: `DATA_TYPE, `ADDR_TYPE, `ROB_INDEX_TYPE, `OPENUM_TYPE, `TRUE/`FALSE, plus new `RS_SIZE/`RS_INDEX_TYPE.
- One sub-module, rs_priority_enc: a combinational lowest-set-bit finder with a found flag, instantiated twice (free-slot search, ready search).

Test Plan:
1. Reset, then issue ADDI (op=OPENUM_ADDI, rs1_val=5, depend 0, imm=7, rob 3) at edge 0 -> rs_to_alu_ready=1 in cycle 2 with rs1_val=5, imm=7, rob_index=3; rs_full=0 throughout.
2. Issue ADD with rs1_depend=2, rs2_val=9; ALU CDB tag 2 val 0x10 two cycles later -> dispatch exactly 2 cycles after the CDB edge with rs1_val=0x10, rs2_val=9.
3. Issue with rs1_depend=4 while LSB CDB tag 4 val 0xAB is in the same cycle -> entry stored ready; dispatched 2 cycles later with rs1_val=0xAB.
4. Fill 16 entries all depending on tag 5 -> rs_full=1. Broadcast ALU tag 5 -> 16 dispatches on consecutive cycles in index order; rs_full falls the cycle after the first dispatch.
5. Fill 6 waiting entries, assert rollback with a concurrent issue -> next cycle rs_full=0, no dispatch ever. A later CDB for any tag produces no dispatch.
6. Ready entry pending, rdy_in low for 3 cycles -> no dispatch during the stall. Dispatch occurs 1 cycle after rdy_in returns, with data unchanged.
